// File: rtl/vga_controller_pkg.sv
// Shared geometry, state encoding and grid_out indexing for the falling-block
// playfield controller.
package vga_controller_pkg;

  localparam int GRID_W     = 16;
  localparam int GRID_H     = 16;
  localparam int PIECE_SIZE = 2;
  localparam int COORD_W    = $clog2(GRID_W);
  localparam int GRID_BITS  = GRID_W * GRID_H;
  localparam int IDX_W      = $clog2(GRID_BITS);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // board[row][col]: one word per row so a full-row test is a single reduction.
  typedef logic [GRID_H-1:0][GRID_W-1:0] board_t;

  typedef enum logic [2:0] {
    S_PLAY,
    S_LOCK,
    S_CLEAR,
    S_SPAWN,
    S_OVER
  } state_t;

  function automatic idx_t grid_idx(input int col, input int row);
    return idx_t'(col * GRID_H + row);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an asynchronous level button followed by a
// single-cycle rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic sync0, sync1, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples its pre-edge input;
      // blocking here would collapse the synchronizer chain into one stage.
      sync0 <= btn;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign rise = sync1 & ~prev;

endmodule

// File: rtl/vga_controller.sv
// 16x16 playfield with one falling 2x2 piece: gravity timer, guarded left/right
// moves, lock, full-row clearing, respawn and game-over freeze.
module vga_controller
  import vga_controller_pkg::*;
#(
  parameter int DROP_PERIOD = 50_000_000,
  parameter int SPAWN_X     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 left,
  input  logic                 right,
  output logic [GRID_BITS-1:0] grid_out
);

  localparam int     CNT_W   = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
  localparam coord_t SPAWN_C = coord_t'(SPAWN_X);

  state_t           state, state_n;
  board_t           board, board_n;
  coord_t           x, x_n, y, y_n, scan, scan_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pend_l, pend_l_n, pend_r, pend_r_n;
  logic             rise_l, rise_r, req_l, req_r, tick;

  btn_edge u_left  (.clk(clk), .reset(reset), .btn(left),  .rise(rise_l));
  btn_edge u_right (.clk(clk), .reset(reset), .btn(right), .rise(rise_r));

  // True when a piece at (px, py) is inside the field and overlaps no locked cell.
  function automatic logic fits(input board_t b, input int px, input int py);
    coord_t c, r;
    if (px < 0 || py < 0 || px > GRID_W - PIECE_SIZE || py > GRID_H - PIECE_SIZE)
      return 1'b0;
    c = coord_t'(px);
    r = coord_t'(py);
    return !(b[r][c] | b[r][c + 1'b1] | b[r + 1'b1][c] | b[r + 1'b1][c + 1'b1]);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_n  = state;
    board_n  = board;
    x_n      = x;
    y_n      = y;
    scan_n   = scan;
    cnt_n    = cnt;
    pend_l_n = 1'b0;
    pend_r_n = 1'b0;
    req_l    = rise_l | pend_l;
    req_r    = rise_r | pend_r;
    tick     = (cnt == CNT_W'(DROP_PERIOD - 1));

    unique case (state)
      S_PLAY: begin
        cnt_n = tick ? '0 : cnt + 1'b1;
        if (tick) begin
          // Gravity owns this cycle; moves wait one cycle and are re-validated.
          pend_l_n = req_l;
          pend_r_n = req_r;
          if (fits(board, int'(x), int'(y) + 1)) y_n = y + 1'b1;
          else                                   state_n = S_LOCK;
        end else if (req_l && !req_r) begin
          if (fits(board, int'(x) - 1, int'(y))) x_n = x - 1'b1;
        end else if (req_r && !req_l) begin
          if (fits(board, int'(x) + 1, int'(y))) x_n = x + 1'b1;
        end
      end
      S_LOCK: begin
        board_n[y][x]                 = 1'b1;
        board_n[y][x + 1'b1]          = 1'b1;
        board_n[y + 1'b1][x]          = 1'b1;
        board_n[y + 1'b1][x + 1'b1]   = 1'b1;
        scan_n  = coord_t'(GRID_H - 1);
        state_n = S_CLEAR;
      end
      S_CLEAR: begin
        if (&board[scan]) begin
          // Collapse everything above the full row; rescan the same row next.
          for (int r = 1; r < GRID_H; r++)
            if (r <= int'(scan)) board_n[coord_t'(r)] = board[coord_t'(r - 1)];
          board_n[0] = '0;
        end else if (scan == '0) begin
          state_n = S_SPAWN;
        end else begin
          scan_n = scan - 1'b1;
        end
      end
      S_SPAWN: begin
        x_n     = SPAWN_C;
        y_n     = '0;
        cnt_n   = '0;
        state_n = fits(board, SPAWN_X, 0) ? S_PLAY : S_OVER;
      end
      S_OVER: ;
      default: state_n = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_PLAY;
      // NOTE: the board is ordinary flops rather than RAM, so it is cleared by
      // the async reset and an interrupted LOCK/CLEAR leaves no residue.
      board  <= '0;
      x      <= SPAWN_C;
      y      <= '0;
      scan   <= '0;
      cnt    <= '0;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      state  <= state_n;
      board  <= board_n;
      x      <= x_n;
      y      <= y_n;
      scan   <= scan_n;
      cnt    <= cnt_n;
      pend_l <= pend_l_n;
      pend_r <= pend_r_n;
    end
  end

  always_comb begin
    grid_out = '0;
    for (int c = 0; c < GRID_W; c++)
      for (int r = 0; r < GRID_H; r++)
        grid_out[grid_idx(c, r)] = board[coord_t'(r)][coord_t'(c)] |
                                   ((state != S_OVER) &&
                                    (c == int'(x) || c == int'(x) + 1) &&
                                    (r == int'(y) || r == int'(y) + 1));
  end

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller with DROP_PERIOD=4: expected playfields
// are queued as stimulus is applied and compared when the DUT reaches them.
module tb_vga_controller;

  localparam int DP = 4;
  localparam int SX = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         left = 1'b0;
  logic         right = 1'b0;
  logic [255:0] grid_out;

  vga_controller #(.DROP_PERIOD(DP), .SPAWN_X(SX)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .grid_out(grid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [255:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   t = 0;  // clock edges since the last reset release

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: grid_out=%h expected=%h", tag, got, want);
  endtask

  function automatic logic [255:0] piece(input int px, input int py);
    logic [255:0] g;
    g = '0;
    for (int dc = 0; dc < 2; dc++)
      for (int dr = 0; dr < 2; dr++)
        g[(px + dc) * 16 + py + dr] = 1'b1;
    return g;
  endfunction

  task automatic push_exp(input string tag, input logic [255:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  // Called at a falling edge, well away from the active edge.
  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: no expected value queued");
    end else begin
      e = sb.pop_front();
      check(e.tag, grid_out, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask

  task automatic wait_to(input int abs_t);
    if (abs_t > t) step(abs_t - t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    t = 0;
  endtask

  task automatic pulse(input bit go_right);
    if (go_right) right = 1'b1; else left = 1'b1;
    step(2);
    right = 1'b0;
    left  = 1'b0;
    step(2);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] bd;
    int base, tx, yf;

    // Reset state and first gravity step.
    do_reset();
    push_exp("reset_state", piece(7, 0));          pop_cmp();
    step(3);
    push_exp("no_fall_before_tick", piece(7, 0));  pop_cmp();
    step(1);
    push_exp("first_tick", piece(7, 1));           pop_cmp();

    // Held right button moves exactly once.
    do_reset();
    wait_to(20); right = 1'b1;
    wait_to(30);
    push_exp("hold_right_once", piece(8, 7));      pop_cmp();
    wait_to(40);
    push_exp("hold_right_no_repeat", piece(8, 10)); pop_cmp();
    right = 1'b0;

    // Right pulses stop at the wall; a left pulse then moves back.
    do_reset();
    repeat (8) pulse(1'b1);
    wait_to(36);
    push_exp("right_stop_at_14", piece(14, 9));    pop_cmp();
    pulse(1'b1);
    wait_to(44);
    push_exp("ninth_right_ignored", piece(14, 11)); pop_cmp();
    pulse(1'b0);
    wait_to(52);
    push_exp("left_move", piece(13, 13));          pop_cmp();

    // Simultaneous left and right edges cancel.
    do_reset();
    left = 1'b1; right = 1'b1;
    wait_to(6);
    left = 1'b0; right = 1'b0;
    wait_to(10);
    push_exp("coincident_dropped", piece(7, 2));   pop_cmp();

    // Free fall to the floor, lock, respawn.
    do_reset();
    wait_to(56);
    push_exp("fall_to_14", piece(7, 14));          pop_cmp();
    wait_to(59);
    push_exp("stay_at_14", piece(7, 14));          pop_cmp();
    wait_to(70);
    push_exp("during_clear", piece(7, 14));        pop_cmp();
    wait_to(80);
    push_exp("locked_and_respawn", piece(7, 14) | piece(7, 0)); pop_cmp();
    wait_to(82);
    push_exp("respawn_falls", piece(7, 14) | piece(7, 1));      pop_cmp();

    // Reset during CLEAR discards the partly built board.
    do_reset();
    wait_to(65);
    do_reset();
    push_exp("reset_mid_clear", piece(7, 0));      pop_cmp();

    // Fill the bottom two rows with eight pieces; both rows clear.
    do_reset();
    bd = '0;
    for (int i = 0; i < 8; i++) begin
      tx   = 2 * i;
      base = t;
      if (tx < SX) repeat (SX - tx) pulse(1'b0);
      else         repeat (tx - SX) pulse(1'b1);
      bd |= piece(tx, 14);
      if (i < 7) begin
        wait_to(base + 78);
        push_exp($sformatf("row_fill_%0d", i), bd | piece(7, 0));
      end else begin
        wait_to(base + 80);
        push_exp("rows_cleared", piece(7, 0));
      end
      pop_cmp();
    end

    // Stack at the spawn column until the spawn collides.
    do_reset();
    bd = '0;
    for (int j = 1; j <= 8; j++) begin
      yf   = 16 - 2 * j;
      base = t;
      bd  |= piece(7, yf);
      wait_to(base + 4 * (yf + 1) + 18);
      if (j < 8) push_exp($sformatf("stack_%0d", j), bd | piece(7, 0));
      else       push_exp("game_over", bd);
      pop_cmp();
    end
    repeat (3) pulse(1'b0);
    repeat (3) pulse(1'b1);
    step(10);
    push_exp("over_frozen", bd);                   pop_cmp();
    do_reset();
    push_exp("reset_after_over", piece(7, 0));     pop_cmp();
    step(4);
    push_exp("play_after_over", piece(7, 1));      pop_cmp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 SHALL have parameter DROP_PERIOD, default 50_000_000, clock cycles per gravity step (0.5 s at 100 MHz).
REQ-002 SHALL have parameter SPAWN_X, default 7, leftmost column of a newly spawned piece.
REQ-003 SHALL have port clk, input, 1 bit, 100 MHz system clock (sole clock).
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port left, input, 1 bit, asynchronous move-left button, level.
REQ-006 SHALL have port right, input, 1 bit, asynchronous move-right button, level.
REQ-007 SHALL have port grid_out, output, 256 bits, 16x16 playfield, bit (col*16 + row) = 1 when cell occupied; row 0 = top, col 0 = left.

Function
REQ-008 SHALL hold a 16x16 locked-cell board plus one active 2x2 square piece at (x, y), x in 0..14 (left column), y in 0..14 (top row).
REQ-009 grid_out SHALL equal board OR active-piece cells, combinationally from registers; in OVER the piece is not shown.
REQ-010 left/right SHALL pass a 2-flop synchronizer then rising-edge detection; one move request per rising edge, no auto-repeat while held.
REQ-011 A move request SHALL be accepted only if the target position is in 0..14 and its 4 cells are free in board; otherwise dropped silently.
REQ-012 If left and right requests coincide, both SHALL be dropped.
REQ-013 Drop counter SHALL count 0..DROP_PERIOD-1 in PLAY; tick on terminal count, then wrap to 0.
REQ-014 On a tick, move requests in that cycle SHALL be held pending and applied in the next PLAY cycle (re-checked against bounds/board).
REQ-015 On a tick: if y<14 and row y+2 cols x,x+1 free, y increments; else state goes to LOCK.
REQ-016 States SHALL be PLAY, LOCK, CLEAR, SPAWN, OVER.
REQ-017 LOCK (1 cycle): OR piece cells into board; go to CLEAR with scan row = 15.
REQ-018 CLEAR: one row per cycle; if scan row full, rows above shift down by one, row 0 zeroed, same row re-scanned; else scan row decrements; after row 0 checked go to SPAWN.
REQ-019 SPAWN (1 cycle): x=SPAWN_X, y=0, drop counter=0; if any of the 4 cells occupied go to OVER, else PLAY.
REQ-020 OVER SHALL freeze board and ignore inputs until reset.
REQ-021 Inputs SHALL be ignored in LOCK, CLEAR, SPAWN (edges discarded, no pending).

Reset
REQ-022 On reset low, asynchronously: board all 0, x=SPAWN_X, y=0, drop counter 0, pending moves cleared, synchronizers 0, state PLAY.
REQ-023 After reset grid_out SHALL show only the spawn piece (bits 112,113,128,129 at default SPAWN_X).
REQ-024 Reset asserted mid-LOCK/CLEAR SHALL abort the operation with no partial board retained.

Structure
REQ-025 Shared package SHALL hold GRID_W=16, GRID_H=16, PIECE_SIZE=2, the state enum, and the grid_out index function (col*16+row).
REQ-026 One sub-module btn_edge (synchronizer + rising-edge detect) SHALL be instantiated for left and right.

Verification (DROP_PERIOD=4)
REQ-027 Reset release, no input -> grid_out bits 112,113,128,129 only.
REQ-028 right held high continuously from cycle 20 -> piece moves exactly once to x=8 (bits 128,129,144,145), no further motion.
REQ-029 Eight right pulses -> x stops at 14 (bits 224,225,240,241); a ninth pulse changes nothing.
REQ-030 No input -> y reaches 14 after 14 ticks; 15th tick locks rows 14-15 cols 7-8 into board; new piece at x=7,y=0.
REQ-031 Eight pieces placed at x=0,2,...,14 -> rows 14-15 fill, both cleared, board all 0 after CLEAR.
REQ-032 Eight pieces stacked at x=7 -> eighth locks at rows 0-1, spawn collides -> OVER; grid frozen under inputs; reset restores REQ-027 state.
